dpram_arbiter: RTL

- Shares one 64x8 true dual-port RAM among NREQ requesters.
- Each cycle the block grants up to two non-conflicting requests, one to RAM port A and one to RAM port B, using a rotating round-robin priority.
- Read data returns one cycle after the grant, on the requester's own response lane.
- Sits between client engines (DMA, CPU-side register bank, etc.) and the storage array.

---
 rtl/dpram_pkg.sv | 29 ++
 rtl/dpram_core.sv | 38 +++
 rtl/dpram_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/dpram_pkg.sv
// Shared definitions for the dual-port RAM arbiter: default sizes and the
// grant helper functions used by the scan logic.
package dpram_pkg;

    localparam int unsigned NREQ_DEF   = 4;
    localparam int unsigned DW_DEF     = 8;
    localparam int unsigned AW_DEF     = 6;
    localparam int unsigned CW_DEF     = 16;
    localparam int unsigned ADDR_MAX_W = 16;

    // Two accesses collide when they hit the same word and either one writes.
    function automatic logic conflict(
        input logic [ADDR_MAX_W-1:0] addr_a,
        input logic                  we_a,
        input logic [ADDR_MAX_W-1:0] addr_b,
        input logic                  we_b
    );
        return (addr_a == addr_b) && (we_a || we_b);
    endfunction

    // Round-robin successor of idx among nreq requesters.
    function automatic int unsigned rr_next(
        input int unsigned idx,
        input int unsigned nreq
    );
        return ((idx + 32'd1) >= nreq) ? 32'd0 : (idx + 32'd1);
    endfunction

endpackage

// File: rtl/dpram_core.sv
// Two-port RAM with independent write enables and registered read data.
// Ports: clk; per port x in {a,b}: en_x, we_x, addr_x, wdata_x, rdata_x.
// rdata_x updates only on a read (en && !we) and holds otherwise.
module dpram_core
    import dpram_pkg::*;
#(
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned AW = AW_DEF
)(
    input  logic          clk,
    input  logic          en_a,
    input  logic          we_a,
    input  logic [AW-1:0] addr_a,
    input  logic [DW-1:0] wdata_a,
    output logic [DW-1:0] rdata_a,
    input  logic          en_b,
    input  logic          we_b,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] wdata_b,
    output logic [DW-1:0] rdata_b
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    // Storage array is never reset.
    always_ff @(posedge clk) begin
        if (en_a && we_a) mem[addr_a] <= wdata_a;
        if (en_b && we_b) mem[addr_b] <= wdata_b;
    end

    always_ff @(posedge clk) begin
        if (en_a && !we_a) rdata_a <= mem[addr_a];
        if (en_b && !we_b) rdata_b <= mem[addr_b];
    end

endmodule

// File: rtl/dpram_arbiter.sv
// Round-robin arbiter sharing one dual-port RAM among NREQ requesters.
// Ports: clk, rst_n (async active-low); req_valid/req_we/req_addr/req_wdata
// request bundle (packed per requester); req_ready combinational grant;
// rsp_valid one-cycle read pulse per lane; rsp_rdata per-lane read data held
// until the next response; conflict_cnt saturating conflict-cycle counter.
module dpram_arbiter
    import dpram_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned DW   = DW_DEF,
    parameter int unsigned AW   = AW_DEF,
    parameter int unsigned CW   = CW_DEF
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [NREQ*DW-1:0] rsp_rdata,
    output logic [CW-1:0]      conflict_cnt
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt;
    logic [PW-1:0] scan_idx [NREQ];
    logic [AW-1:0] addr_l   [NREQ];
    logic [DW-1:0] wdata_l  [NREQ];

    logic          a_vld, b_vld, skip;
    logic [PW-1:0] a_idx, b_idx;

    logic          rd_vld_a, rd_vld_b;
    logic [PW-1:0] rd_lane_a, rd_lane_b;
    logic [DW-1:0] rdata_a, rdata_b;

    // Unpack the request bus.
    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign addr_l[i]  = req_addr[i*AW +: AW];
        assign wdata_l[i] = req_wdata[i*DW +: DW];
    end

    // Scan order starting at ptr, wrapping modulo NREQ.
    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            scan_idx[k] = PW'((32'(ptr) + 32'(k)) % NREQ);
        end
    end

    // First valid requester wins port A; next non-conflicting one wins port B.
    always_comb begin
        a_vld = 1'b0;
        b_vld = 1'b0;
        a_idx = '0;
        b_idx = '0;
        skip  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (req_valid[scan_idx[k]]) begin
                if (!a_vld) begin
                    a_vld = 1'b1;
                    a_idx = scan_idx[k];
                end else if (!b_vld) begin
                    if (conflict(ADDR_MAX_W'(addr_l[a_idx]), req_we[a_idx],
                                 ADDR_MAX_W'(addr_l[scan_idx[k]]), req_we[scan_idx[k]])) begin
                        skip = 1'b1;
                    end else begin
                        b_vld = 1'b1;
                        b_idx = scan_idx[k];
                    end
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (a_vld) req_ready[a_idx] = 1'b1;
        if (b_vld) req_ready[b_idx] = 1'b1;
    end

    // Priority moves past the last requester served this cycle.
    always_comb begin
        ptr_nxt = ptr;
        if (b_vld)      ptr_nxt = PW'(rr_next(32'(b_idx), NREQ));
        else if (a_vld) ptr_nxt = PW'(rr_next(32'(a_idx), NREQ));
    end

    dpram_core #(
        .DW (DW),
        .AW (AW)
    ) u_core (
        .clk     (clk),
        .en_a    (a_vld),
        .we_a    (a_vld && req_we[a_idx]),
        .addr_a  (addr_l[a_idx]),
        .wdata_a (wdata_l[a_idx]),
        .rdata_a (rdata_a),
        .en_b    (b_vld),
        .we_b    (b_vld && req_we[b_idx]),
        .addr_b  (addr_l[b_idx]),
        .wdata_b (wdata_l[b_idx]),
        .rdata_b (rdata_b)
    );

    // Pointer, read-lane tracking and conflict statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr          <= '0;
            rd_vld_a     <= 1'b0;
            rd_vld_b     <= 1'b0;
            rd_lane_a    <= '0;
            rd_lane_b    <= '0;
            conflict_cnt <= '0;
        end else begin
            ptr       <= ptr_nxt;
            rd_vld_a  <= a_vld && !req_we[a_idx];
            rd_vld_b  <= b_vld && !req_we[b_idx];
            rd_lane_a <= a_idx;
            rd_lane_b <= b_idx;
            if (skip && (conflict_cnt != {CW{1'b1}})) begin
                conflict_cnt <= conflict_cnt + CW'(1);
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (rd_vld_a) rsp_valid[rd_lane_a] = 1'b1;
        if (rd_vld_b) rsp_valid[rd_lane_b] = 1'b1;
    end

    // Each lane shows fresh RAM data in its response cycle, else the last value.
    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        logic [DW-1:0] lane_d;
        logic [DW-1:0] lane_q;

        always_comb begin
            lane_d = lane_q;
            if (rd_vld_a && (rd_lane_a == PW'(i)))      lane_d = rdata_a;
            else if (rd_vld_b && (rd_lane_b == PW'(i))) lane_d = rdata_b;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) lane_q <= '0;
            else        lane_q <= lane_d;
        end

        assign rsp_rdata[i*DW +: DW] = lane_d;
    end

endmodule
